// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and immediate-format helpers shared by the decode stage
// and the branch predictor.
package rv_isa_pkg;

    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [2:0] F3_ADD_SUB   = 3'd0;
    localparam logic [2:0] F3_SLL       = 3'd1;
    localparam logic [2:0] F3_SRL_SRA   = 3'd5;
    localparam logic [2:0] F3_LD        = 3'd3;
    localparam logic [2:0] F3_LWU       = 3'd6;
    localparam logic [2:0] F3_LDU       = 3'd7;
    localparam logic [2:0] F3_SW        = 3'd2;
    localparam logic [2:0] F3_BR_RSV2   = 3'd2;
    localparam logic [2:0] F3_BR_RSV3   = 3'd3;
    localparam logic [2:0] F3_JALR      = 3'd0;

    localparam logic [6:0] F7_BASE      = 7'h00;
    localparam logic [6:0] F7_ALT       = 7'h20;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // FENCE and SYSTEM carry their fields in the I-type slot, so they take the I format.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:        fmt = IMM_I;
            OPC_STORE:                       fmt = IMM_S;
            OPC_BRANCH:                      fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:              fmt = IMM_U;
            OPC_JAL:                         fmt = IMM_J;
            default:                         fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/idu_pipe_if.sv
// Decode-stage bus: IF-side request, EX-side decoded entry, load-use inputs and stall counter.
interface idu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic             ex_load_valid_i;
    logic [4:0]       ex_load_rd_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [6:0]       opcode_o;
    logic [2:0]       funct3_o;
    logic [6:0]       funct7_o;
    logic [XLEN-1:0]  imm_o;
    logic [XLEN-1:0]  rs1_data_o;
    logic [XLEN-1:0]  rs2_data_o;
    logic             illegal_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i,
               ex_load_valid_i, ex_load_rd_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o, opcode_o,
               funct3_o, funct7_o, imm_o, rs1_data_o, rs2_data_o, illegal_o, stall_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i,
               ex_load_valid_i, ex_load_rd_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o, opcode_o,
               funct3_o, funct7_o, imm_o, rs1_data_o, rs2_data_o, illegal_o, stall_cnt_o
    );

endinterface

// File: rtl/idu_imm_gen.sv
// Combinational RV immediate builder: scatters the instruction's immediate bits by format
// and sign-extends from inst[31] to XLEN.
module idu_imm_gen
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_inst,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        // Start fully sign-filled, then overlay the format-specific low bits.
        o_imm = {XLEN{i_inst[31]}};
        case (i_fmt)
            IMM_I: o_imm[11:0] = i_inst[31:20];
            IMM_S: o_imm[11:0] = {i_inst[31:25], i_inst[11:7]};
            IMM_B: o_imm[12:0] = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U: o_imm[31:0] = {i_inst[31:12], 12'b0};
            IMM_J: o_imm[20:0] = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/idu_pipe.sv
// Registered RV32I decode stage: field split, immediate build, illegal detection and
// load-use stall, holding one entry behind a valid/ready handshake with flush.
module idu_pipe
    import rv_isa_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    idu_pipe_if.slave  bus
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_illegal;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    imm_fmt_e        w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_accept;

    logic             r_full;
    logic [XLEN-1:0]  r_pc;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_opcode = bus.inst_i[6:0];
    assign w_rd     = bus.inst_i[11:7];
    assign w_funct3 = bus.inst_i[14:12];
    assign w_rs1    = bus.inst_i[19:15];
    assign w_rs2    = bus.inst_i[24:20];
    assign w_funct7 = bus.inst_i[31:25];

    always_comb begin
        w_illegal  = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                // Only SUB and SRA use the alternate funct7.
                w_illegal  = !((w_funct7 == F7_BASE) ||
                               ((w_funct7 == F7_ALT) &&
                                ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA))));
            end
            OPC_OP_IMM: begin
                w_uses_rs1 = 1'b1;
                if (w_funct3 == F3_SLL)
                    w_illegal = (w_funct7 != F7_BASE);
                else if (w_funct3 == F3_SRL_SRA)
                    w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
            end
            OPC_LOAD: begin
                w_uses_rs1 = 1'b1;
                w_illegal  = (w_funct3 == F3_LD) || (w_funct3 == F3_LWU) || (w_funct3 == F3_LDU);
            end
            OPC_STORE: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_illegal  = (w_funct3 > F3_SW);
            end
            OPC_BRANCH: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_illegal  = (w_funct3 == F3_BR_RSV2) || (w_funct3 == F3_BR_RSV3);
            end
            OPC_JALR: begin
                w_uses_rs1 = 1'b1;
                w_illegal  = (w_funct3 != F3_JALR);
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: begin
                w_illegal  = 1'b0;
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    // Illegal words carry a zero immediate so EX never sees a half-decoded value.
    assign w_fmt = w_illegal ? IMM_NONE : imm_fmt_of(w_opcode);

    idu_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_inst (bus.inst_i[31:7]),
        .i_fmt  (w_fmt),
        .o_imm  (w_imm)
    );

    assign w_hazard = bus.in_valid_i && bus.ex_load_valid_i && (bus.ex_load_rd_i != 5'd0) &&
                      ((w_uses_rs1 && (w_rs1 == bus.ex_load_rd_i)) ||
                       (w_uses_rs2 && (w_rs2 == bus.ex_load_rd_i)));

    assign w_in_ready = (!r_full || bus.out_ready_i) && !w_hazard && !bus.flush_i;
    assign w_accept   = bus.in_valid_i && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= 1'b0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.flush_i)
                r_full <= 1'b0;
            else if (w_accept)
                r_full <= 1'b1;
            else if (bus.out_ready_i)
                r_full <= 1'b0;

            // Data fields are only written on accept; a drained entry keeps its last value.
            if (w_accept) begin
                r_pc       <= bus.pc_i;
                r_rd       <= w_rd;
                r_rs1      <= w_rs1;
                r_rs2      <= w_rs2;
                r_opcode   <= w_opcode;
                r_funct3   <= w_funct3;
                r_funct7   <= w_funct7;
                r_imm      <= w_imm;
                r_rs1_data <= bus.rs1_data_i;
                r_rs2_data <= bus.rs2_data_i;
                r_illegal  <= w_illegal;
            end

            if (w_hazard && !bus.flush_i && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_full;
    assign bus.pc_o        = r_pc;
    assign bus.rd_o        = r_rd;
    assign bus.rs1_o       = r_rs1;
    assign bus.rs2_o       = r_rs2;
    assign bus.opcode_o    = r_opcode;
    assign bus.funct3_o    = r_funct3;
    assign bus.funct7_o    = r_funct7;
    assign bus.imm_o       = r_imm;
    assign bus.rs1_data_o  = r_rs1_data;
    assign bus.rs2_data_o  = r_rs2_data;
    assign bus.illegal_o   = r_illegal;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule
